// File: rtl/add_3layers_pkg.sv
// Shared types and sizing helpers for the three-plane pixel adder.
package add_3layers_pkg;

  localparam int unsigned D_DEFAULT      = 299;
  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    LOAD1 = 2'd0,
    LOAD2 = 2'd1,
    SUM   = 2'd2
  } state_e;

  function automatic int unsigned frame_size(input int unsigned d);
    return d * d;
  endfunction

  function automatic int unsigned addr_width(input int unsigned t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

  localparam int unsigned T      = frame_size(D_DEFAULT);
  localparam int unsigned ADDR_W = addr_width(T);

endpackage

// File: rtl/add3_frame_buf.sv
// Single-port frame buffer: synchronous write, registered synchronous read.
module add3_frame_buf #(
  parameter int unsigned DEPTH  = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately not reset; every frame rewrites them before use.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/add_3layers.sv
// Loads planes 1 and 2 into frame buffers, then streams out pxl1+pxl2+pxl3 as plane 3 arrives.
module add_3layers
  import add_3layers_pkg::*;
#(
  parameter int unsigned D          = 299,
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in_1,
  input  logic                  valid_in_2,
  input  logic                  valid_in_3,
  input  logic [data_width-1:0] pxl_in_1,
  input  logic [data_width-1:0] pxl_in_2,
  input  logic [data_width-1:0] pxl_in_3,
  output logic [data_width-1:0] pxl_out,
  output logic                  valid_out
);

  localparam int unsigned PT = frame_size(D);
  localparam int unsigned AW = addr_width(PT);
  localparam logic [AW-1:0] LAST = AW'(PT - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [data_width-1:0] pxl3_q, pxl3_d;
  logic                  vld1_q, vld1_d;
  logic [data_width-1:0] pxl_out_q, pxl_out_d;
  logic                  valid_out_q, valid_out_d;

  logic                  we1_c, we2_c, re_c;
  logic [data_width-1:0] rd1_c, rd2_c;

  add3_frame_buf #(.DEPTH(PT), .DATA_W(data_width), .ADDR_W(AW)) u_buf1 (
    .clk  (clk),
    .addr (cnt_q),
    .we   (we1_c),
    .wdata(pxl_in_1),
    .re   (re_c),
    .rdata(rd1_c)
  );

  add3_frame_buf #(.DEPTH(PT), .DATA_W(data_width), .ADDR_W(AW)) u_buf2 (
    .clk  (clk),
    .addr (cnt_q),
    .we   (we2_c),
    .wdata(pxl_in_2),
    .re   (re_c),
    .rdata(rd2_c)
  );

  // Next-state, buffer strobes and the two-stage sum pipeline.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pxl3_d      = pxl3_q;
    vld1_d      = 1'b0;
    we1_c       = 1'b0;
    we2_c       = 1'b0;
    re_c        = 1'b0;
    valid_out_d = vld1_q;
    pxl_out_d   = pxl_out_q;

    unique case (state_q)
      LOAD1: begin
        if (valid_in_1) begin
          we1_c = 1'b1;
          if (cnt_q == LAST) begin
            state_d = LOAD2;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      LOAD2: begin
        if (valid_in_2) begin
          we2_c = 1'b1;
          if (cnt_q == LAST) begin
            state_d = SUM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      SUM: begin
        if (valid_in_3) begin
          re_c   = 1'b1;
          pxl3_d = pxl_in_3;
          vld1_d = 1'b1;
          if (cnt_q == LAST) begin
            state_d = LOAD1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD1;
        cnt_d   = '0;
      end
    endcase

    // Sum wraps modulo 2^data_width; output holds between valid beats.
    if (vld1_q) pxl_out_d = rd1_c + rd2_c + pxl3_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD1;
      cnt_q       <= '0;
      pxl3_q      <= '0;
      vld1_q      <= 1'b0;
      pxl_out_q   <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pxl3_q      <= pxl3_d;
      vld1_q      <= vld1_d;
      pxl_out_q   <= pxl_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign pxl_out   = pxl_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_add_3layers.sv
// Directed table-driven bench for add_3layers with D=3.
module tb_add_3layers;

  localparam int unsigned D  = 3;
  localparam int unsigned W  = 32;
  localparam int unsigned NP = D * D;
  localparam int unsigned NF = 5;

  typedef struct {
    logic [W-1:0] p1  [NP];
    logic [W-1:0] p2  [NP];
    logic [W-1:0] p3  [NP];
    logic [W-1:0] exp [NP];
    bit           hold;
    bit           gap;
  } frame_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in_1, valid_in_2, valid_in_3;
  logic [W-1:0] pxl_in_1, pxl_in_2, pxl_in_3;
  logic [W-1:0] pxl_out;
  logic         valid_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] out_val [$];
  int           out_cyc [$];
  int           pres_cyc[$];
  frame_t       frames  [NF];

  add_3layers #(.D(D), .data_width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in_1(valid_in_1),
    .valid_in_2(valid_in_2),
    .valid_in_3(valid_in_3),
    .pxl_in_1  (pxl_in_1),
    .pxl_in_2  (pxl_in_2),
    .pxl_in_3  (pxl_in_3),
    .pxl_out   (pxl_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && valid_out) begin
      out_val.push_back(pxl_out);
      out_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v1, input logic [W-1:0] p1,
                       input logic v2, input logic [W-1:0] p2,
                       input logic v3, input logic [W-1:0] p3, input bit rec);
    @(negedge clk);
    valid_in_1 = v1; pxl_in_1 = p1;
    valid_in_2 = v2; pxl_in_2 = p2;
    valid_in_3 = v3; pxl_in_3 = p3;
    if (rec && v3) pres_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic send_frame(input int f);
    int k;
    int g;
    bit h;
    h = frames[f].hold;
    for (int i = 0; i < int'(NP); i++)
      drive(1'b1, frames[f].p1[i], 1'b0, '0, h, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < int'(NP); i++)
      drive(h, 32'hFFFF_FFFF, 1'b1, frames[f].p2[i], h, 32'hDEAD_BEEF, 1'b0);
    k = 0;
    g = 0;
    while (k < int'(NP)) begin
      // Gap pattern 1,0,1,1,0 repeating
      if (frames[f].gap && (g % 5 == 1 || g % 5 == 4)) begin
        drive(h, 32'hFFFF_FFFF, h, 32'hFFFF_FFFF, 1'b0, '0, 1'b1);
      end else begin
        drive(h, 32'hFFFF_FFFF, h, 32'hFFFF_FFFF, 1'b1, frames[f].p3[k], 1'b1);
        k++;
      end
      g++;
    end
  endtask

  task automatic clear_q();
    out_val.delete();
    out_cyc.delete();
    pres_cyc.delete();
  endtask

  task automatic verify(input string tag, input int first, input int nfr);
    int n;
    n = nfr * int'(NP);
    chk({tag, "_out_count"}, W'(out_val.size()), W'(n));
    chk({tag, "_pres_count"}, W'(pres_cyc.size()), W'(n));
    for (int i = 0; i < n; i++) begin
      if (i < out_val.size()) begin
        chk($sformatf("%s_sum%0d", tag, i), out_val[i],
            frames[first + i / int'(NP)].exp[i % int'(NP)]);
        if (i < pres_cyc.size())
          chk($sformatf("%s_lat%0d", tag, i), W'(out_cyc[i]), W'(pres_cyc[i] + 2));
      end
    end
  endtask

  initial begin
    // Frame 0: basic ramps
    for (int i = 0; i < int'(NP); i++) begin
      frames[0].p1[i] = W'(1 + i);
      frames[0].p2[i] = W'(10 + i);
      frames[0].p3[i] = W'(100 + i);
    end
    frames[0].exp  = '{111, 114, 117, 120, 123, 126, 129, 132, 135};
    frames[0].hold = 1'b0;
    frames[0].gap  = 1'b0;
    // Frame 1: same data, foreign valids held high
    frames[1]      = frames[0];
    frames[1].hold = 1'b1;
    // Frame 2: overflow wrap
    for (int i = 0; i < int'(NP); i++) begin
      frames[2].p1[i] = 32'h8000_0000;
      frames[2].p2[i] = 32'h8000_0000;
      frames[2].p3[i] = 32'h0000_0001;
      frames[2].exp[i] = 32'h0000_0001;
    end
    frames[2].hold = 1'b0;
    frames[2].gap  = 1'b0;
    // Frame 3: gapped plane 3 with negative plane 2
    for (int i = 0; i < int'(NP); i++) begin
      frames[3].p1[i] = W'(2 * i);
      frames[3].p2[i] = 32'hFFFF_FFFF - W'(i);
      frames[3].p3[i] = W'(1000 + i);
    end
    frames[3].exp  = '{999, 1001, 1003, 1005, 1007, 1009, 1011, 1013, 1015};
    frames[3].hold = 1'b0;
    frames[3].gap  = 1'b1;
    // Frame 4: back-to-back follow-on with different data
    for (int i = 0; i < int'(NP); i++) begin
      frames[4].p1[i] = W'(7 * i);
      frames[4].p2[i] = W'(3);
      frames[4].p3[i] = W'(50);
    end
    frames[4].exp  = '{53, 60, 67, 74, 81, 88, 95, 102, 109};
    frames[4].hold = 1'b0;
    frames[4].gap  = 1'b0;

    reset = 1'b0;
    valid_in_1 = 1'b0; valid_in_2 = 1'b0; valid_in_3 = 1'b0;
    pxl_in_1 = '0; pxl_in_2 = '0; pxl_in_3 = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid_out", W'(valid_out), W'(0));
    chk("reset_pxl_out", pxl_out, '0);
    reset = 1'b1;
    idle(2);

    // All table frames streamed back-to-back
    clear_q();
    for (int f = 0; f < int'(NF); f++) send_frame(f);
    idle(4);
    verify("table", 0, int'(NF));

    // Reset during SUM with sums in flight
    clear_q();
    for (int i = 0; i < int'(NP); i++) drive(1'b1, W'(5), 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < int'(NP); i++) drive(1'b0, '0, 1'b1, W'(6), 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, W'(7), 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, W'(8), 1'b0);
    @(negedge clk);
    valid_in_3 = 1'b0;
    reset = 1'b0;
    #1;
    chk("sum_rst_valid_out", W'(valid_out), W'(0));
    chk("sum_rst_pxl_out", pxl_out, '0);
    @(negedge clk);
    reset = 1'b1;
    clear_q();
    idle(4);
    chk("sum_rst_no_drain", W'(out_val.size()), W'(0));

    // Reset in the middle of LOAD2, then a fresh frame
    clear_q();
    for (int i = 0; i < int'(NP); i++) drive(1'b1, 32'h5555_5555, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 32'h3333_3333, 1'b0, '0, 1'b0);
    @(negedge clk);
    valid_in_2 = 1'b0;
    reset = 1'b0;
    #1;
    chk("load2_rst_valid_out", W'(valid_out), W'(0));
    @(negedge clk);
    reset = 1'b1;
    send_frame(0);
    idle(4);
    verify("fresh", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
